// File: rtl/ysyx_24110006_pkg.sv
// Shared types and constants for the ysyx_24110006 fetch front end.
// Holds the fetch sequencer state encoding and bus response codes.
package ysyx_24110006_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h2000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DELIV = 3'd3,
        ST_WAIT  = 3'd4
    } fetch_state_e;

    // Any response other than OKAY marks the fetched word as an access fault.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_24110006_fetch_ctrl.sv
// Multicycle instruction-fetch sequencer: owns the PC, issues one AR/R read per
// instruction, presents inst+pc to decode and waits for retirement before refetching.
module ysyx_24110006_fetch_ctrl
    import ysyx_24110006_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    output logic [XLEN-1:0] o_araddr,
    output logic            o_arvalid,
    input  logic            i_arready,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_rresp,
    input  logic            i_rvalid,
    output logic            o_rready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid,
    output logic            o_fault,
    input  logic            i_ready,
    input  logic            i_retire,
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            fault_q, fault_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            valid_q, valid_d;

    // Next-state, PC and instruction-latch logic; handshake outputs follow the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_arready) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (i_rvalid) begin
                    state_d = ST_DELIV;
                    inst_d  = i_rdata;
                    fault_d = resp_is_fault(i_rresp);
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DELIV: begin
                if (i_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DELIV;
                end
            end
            ST_WAIT: begin
                // PC only moves here; retire/jump in any other state are ignored.
                if (i_retire) begin
                    state_d = ST_REQ;
                    if (i_jump) begin
                        pc_d = i_jump_pc;
                    end else begin
                        pc_d = pc_q + XLEN'(32'd4);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        arvalid_d = (state_d == ST_REQ);
        rready_d  = (state_d == ST_RESP);
        valid_d   = (state_d == ST_DELIV);
    end

    // State, PC, instruction and handshake registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            fault_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
        end
    end

    assign o_araddr  = pc_q;
    assign o_pc      = pc_q;
    assign o_arvalid = arvalid_q;
    assign o_rready  = rready_q;
    assign o_valid   = valid_q;
    assign o_inst    = inst_q;
    assign o_fault   = fault_q;

endmodule

// File: tb/tb_ysyx_24110006_fetch_ctrl.sv
// Directed bench for ysyx_24110006_fetch_ctrl: a per-cycle vector table for normal
// fetch/jump/fault/wrap sequencing plus hand-written stall and async-reset sequences.
module tb_ysyx_24110006_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic        ready;
    logic        retire;
    logic        jump;
    logic [31:0] jump_pc;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] RST_PC = 32'h2000_0000;
    localparam logic [31:0] I0 = 32'h0000_0413;
    localparam logic [31:0] I1 = 32'h0044_8493;
    localparam logic [31:0] I2 = 32'h00A0_0513;
    localparam logic [31:0] I3 = 32'h0010_0073;
    localparam logic [31:0] I4 = 32'hFFF0_0093;
    localparam logic [31:0] I5 = 32'h1234_5678;

    ysyx_24110006_fetch_ctrl dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .o_araddr  (araddr),
        .o_arvalid (arvalid),
        .i_arready (arready),
        .i_rdata   (rdata),
        .i_rresp   (rresp),
        .i_rvalid  (rvalid),
        .o_rready  (rready),
        .o_inst    (inst),
        .o_pc      (pc),
        .o_valid   (valid),
        .o_fault   (fault),
        .i_ready   (ready),
        .i_retire  (retire),
        .i_jump    (jump),
        .i_jump_pc (jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a;
        logic        v;
        logic [31:0] d;
        logic [1:0]  r;
        logic        y;
        logic        t;
        logic        j;
        logic [31:0] p;
        logic        e_arvalid;
        logic        e_rready;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic a, input logic v, input logic [31:0] d,
                                input logic [1:0] r, input logic y, input logic t,
                                input logic j, input logic [31:0] p,
                                input logic ea, input logic er, input logic ev,
                                input logic ef, input logic [31:0] eaddr,
                                input logic [31:0] einst);
        vec_t x;
        x.a = a; x.v = v; x.d = d; x.r = r; x.y = y; x.t = t; x.j = j; x.p = p;
        x.e_arvalid = ea; x.e_rready = er; x.e_valid = ev; x.e_fault = ef;
        x.e_addr = eaddr; x.e_inst = einst;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic v, input logic [31:0] d,
                         input logic [1:0] r, input logic y, input logic t,
                         input logic j, input logic [31:0] p);
        arready = a; rvalid = v; rdata = d; rresp = r;
        ready = y; retire = t; jump = j; jump_pc = p;
    endtask

    task automatic chk_all(input string tag, input logic ea, input logic er, input logic ev,
                           input logic ef, input logic [31:0] eaddr, input logic [31:0] einst);
        chk({tag, ".arvalid"}, {31'd0, arvalid}, {31'd0, ea});
        chk({tag, ".rready"},  {31'd0, rready},  {31'd0, er});
        chk({tag, ".valid"},   {31'd0, valid},   {31'd0, ev});
        chk({tag, ".fault"},   {31'd0, fault},   {31'd0, ef});
        chk({tag, ".araddr"},  araddr, eaddr);
        chk({tag, ".pc"},      pc,     eaddr);
        chk({tag, ".inst"},    inst,   einst);
    endtask

    initial begin
        // Normal sequencing: fetch, sequential retire, jump, fault, wrap, ignored retire.
        vq.push_back(mk(1'b1,1'b1,I0,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0, RST_PC, 32'h0));
        vq.push_back(mk(1'b1,1'b1,I0,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0, RST_PC, 32'h0));
        vq.push_back(mk(1'b1,1'b1,I0,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,1'b0, RST_PC, I0));
        vq.push_back(mk(1'b1,1'b1,I0,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, RST_PC, I0));
        vq.push_back(mk(1'b1,1'b1,I0,2'b00,1'b1,1'b1,1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h2000_0004, I0));
        vq.push_back(mk(1'b1,1'b1,I1,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h2000_0004, I0));
        vq.push_back(mk(1'b1,1'b1,I1,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h2000_0004, I1));
        vq.push_back(mk(1'b1,1'b1,I1,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h2000_0004, I1));
        vq.push_back(mk(1'b1,1'b1,I1,2'b00,1'b1,1'b1,1'b1,32'h8000_0010, 1'b1,1'b0,1'b0,1'b0, 32'h8000_0010, I1));
        vq.push_back(mk(1'b1,1'b1,I2,2'b10,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h8000_0010, I1));
        vq.push_back(mk(1'b1,1'b1,I2,2'b10,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,1'b1, 32'h8000_0010, I2));
        vq.push_back(mk(1'b1,1'b1,I2,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b1, 32'h8000_0010, I2));
        vq.push_back(mk(1'b1,1'b1,I2,2'b00,1'b1,1'b1,1'b0,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h8000_0014, I2));
        vq.push_back(mk(1'b1,1'b1,I3,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b1, 32'h8000_0014, I2));
        vq.push_back(mk(1'b1,1'b1,I3,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h8000_0014, I3));
        vq.push_back(mk(1'b1,1'b1,I3,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h8000_0014, I3));
        vq.push_back(mk(1'b1,1'b1,I3,2'b00,1'b1,1'b1,1'b1,32'hFFFF_FFFC, 1'b1,1'b0,1'b0,1'b0, 32'hFFFF_FFFC, I3));
        vq.push_back(mk(1'b1,1'b1,I4,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'hFFFF_FFFC, I3));
        vq.push_back(mk(1'b1,1'b1,I4,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hFFFF_FFFC, I4));
        vq.push_back(mk(1'b1,1'b1,I4,2'b00,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hFFFF_FFFC, I4));
        vq.push_back(mk(1'b1,1'b1,I4,2'b00,1'b1,1'b1,1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0000_0000, I4));
        vq.push_back(mk(1'b0,1'b1,I4,2'b00,1'b1,1'b1,1'b1,32'hDEAD_BEE0, 1'b1,1'b0,1'b0,1'b0, 32'h0000_0000, I4));

        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (3) step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, RST_PC, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].a, vq[i].v, vq[i].d, vq[i].r, vq[i].y, vq[i].t, vq[i].j, vq[i].p);
            step();
            chk_all($sformatf("vec%0d", i), vq[i].e_arvalid, vq[i].e_rready, vq[i].e_valid,
                    vq[i].e_fault, vq[i].e_addr, vq[i].e_inst);
        end

        // Address stall: arvalid and araddr must hold while arready is low.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, I5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            chk_all($sformatf("ar_stall%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, I4);
        end
        drive(1'b1, 1'b0, I5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("ar_accept", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, I4);
        // Response stall: no delivery until rvalid.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, I5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            chk_all($sformatf("r_stall%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, I4);
        end
        drive(1'b0, 1'b1, I5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("r_accept", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, I5);
        // Decode back-pressure: delivery held stable.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'hBAD0_BAD0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            chk_all($sformatf("deliv_hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, I5);
        end
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("deliv_accept", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, I5);
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk_all("retire_seq", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0004, I5);
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("into_resp", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, I5);

        // Asynchronous reset while waiting for read data.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, RST_PC, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        chk_all("boot", 1'b0, 1'b0, 1'b0, 1'b0, RST_PC, 32'h0);
        step();
        chk_all("refetch", 1'b1, 1'b0, 1'b0, 1'b0, RST_PC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
